// File: rtl/mem_backend_pkg.sv
// mem_backend_pkg: shared types and helpers for the mem_backend block.
//   state_t         - request FSM states (IDLE, WAIT, RESP)
//   DEFAULT_DATA_W  - default data width
//   DEFAULT_LATENCY - default access latency in cycles
//   word_index()    - byte address to word index (drops the two byte-lane bits)
package mem_backend_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_LATENCY = 4;

  // The caller keeps only the low ADDR_W bits of the result.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/mem_backend_array.sv
// mem_backend_array: single-port DATA_W x 2**ADDR_W storage.
// A write takes the port for its cycle; every other cycle the port reads,
// with the read data registered on the clock edge.
// Ports:
//   clk   in  clock, rising edge
//   we    in  write enable (write has priority over the read)
//   addr  in  word index
//   wdata in  write data
//   rdata out registered read data of addr
module mem_backend_array
  import mem_backend_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_backend.sv
// mem_backend: word-addressed backing memory with a fixed access latency,
// serving one valid/ready request at a time and answering with a
// one-cycle response pulse.
// Optional feature macro: MEM_BACKEND_WBUF_EN adds a 1-entry posted write
// buffer (fast write ack, read forwarding, background drain).
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   req_valid  in  request present
//   req_ready  out request can be accepted this cycle
//   req_wr     in  1 = write, 0 = read
//   req_addr   in  byte address; word index = req_addr[ADDR_W+1:2]
//   req_wdata  in  write data
//   resp_valid out one-cycle response pulse
//   resp_wr    out response acknowledges a write
//   resp_rdata out read data, or echoed write data; held between responses
//   busy       out request in flight
module mem_backend
  import mem_backend_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              wr_p0;
  logic [ADDR_W-1:0] idx_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [31:0]       req_widx;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_addr_bits;
  logic              accept;
  logic              commit;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_rdata;

`ifdef MEM_BACKEND_WBUF_EN
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hit;
  logic              drain_p0;
`endif

  assign req_widx         = word_index(req_addr);
  assign req_idx          = req_widx[ADDR_W-1:0];
  assign unused_addr_bits = ^req_widx[31:ADDR_W];

`ifdef MEM_BACKEND_WBUF_EN
  // A full buffer blocks further writes; reads still get through.
  assign req_ready = (state == IDLE) && !(req_wr && wb_valid);
  assign wb_hit    = wb_valid && (req_idx == wb_idx);
`else
  assign req_ready = (state == IDLE);
`endif

  assign accept = req_valid && req_ready;
  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign busy   = (state != IDLE);

  // Reset at the commit edge abandons the access, so it also blocks the write.
  assign arr_we = commit && wr_p0 && !rst;

  // The array read is launched one edge ahead of the commit: from the
  // incoming request while IDLE (covers LATENCY = 1), from the latched index
  // while WAIT. Its registered output is then valid at the commit edge.
  assign arr_addr = (state == IDLE) ? req_idx : idx_p0;

  mem_backend_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wdata_p0),
    .rdata(arr_rdata)
  );

  // Stage p0: request capture
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (accept) begin
        wr_p0    <= req_wr;
        idx_p0   <= req_idx;
        wdata_p0 <= req_wdata;
      end
`ifdef MEM_BACKEND_WBUF_EN
      else if (wb_valid) begin
        wr_p0    <= 1'b1;
        idx_p0   <= wb_idx;
        wdata_p0 <= wb_data;
      end
      if (accept && req_wr) begin
        wb_idx  <= req_idx;
        wb_data <= req_wdata;
      end
`endif
    end
  end

  // Stage p1: access sequencing and response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_rdata <= '0;
`ifdef MEM_BACKEND_WBUF_EN
      wb_valid   <= 1'b0;
      drain_p0   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_BACKEND_WBUF_EN
          if (accept && req_wr) begin
            wb_valid   <= 1'b1;
            resp_valid <= 1'b1;
            resp_wr    <= 1'b1;
            resp_rdata <= req_wdata;
            state      <= RESP;
          end else if (accept && wb_hit) begin
            resp_valid <= 1'b1;
            resp_wr    <= 1'b0;
            resp_rdata <= wb_data;
            state      <= RESP;
          end else if (accept) begin
            cnt      <= LAT_M1;
            drain_p0 <= 1'b0;
            state    <= WAIT;
          end else if (wb_valid) begin
            cnt      <= LAT_M1;
            drain_p0 <= 1'b1;
            state    <= WAIT;
          end
`else
          if (accept) begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
`endif
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
`ifdef MEM_BACKEND_WBUF_EN
          else if (drain_p0) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
`endif
          else begin
            resp_rdata <= wr_p0 ? wdata_p0 : arr_rdata;
            resp_valid <= 1'b1;
            resp_wr    <= wr_p0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_backend.sv
// tb_mem_backend: runs two mem_backend instances (LATENCY 4 and 1) with
// directed and random requests against a transaction-level model.
module tb_mem_backend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int LAT = (gi == 0) ? 4 : 1;

    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_wr;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        done = 1'b0;

    mem_backend #(
      .ADDR_W (8),
      .DATA_W (32),
      .LATENCY(LAT)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_wr   (resp_wr),
      .resp_rdata(resp_rdata),
      .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("L%0d %s", LAT, name), act, exp);
    endtask

    // Transaction model: a request accepted at edge 0 completes at edge LAT
    // (memory updated, response visible) and the block is free after edge LAT+1.
    logic [31:0] m_mem   [256];
    bit          m_known [256];
    int          age = -1;
    bit          m_wr = 1'b0;
    logic [7:0]  m_idx = 8'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    bit          m_rdata_known = 1'b0;
    bit          m_resp_wr = 1'b0;
    bit          chk_en = 1'b0;

    initial begin
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("req_ready", 32'(req_ready), 32'(age < 0));
          chk("busy", 32'(busy), 32'(age >= 0));
          chk("resp_valid", 32'(resp_valid), 32'(age == LAT));
          chk("resp_wr", 32'(resp_wr), 32'(m_resp_wr));
          if (m_rdata_known) chk("resp_rdata", resp_rdata, m_rdata);
        end
        if (rst) begin
          age           = -1;
          m_rdata       = 32'd0;
          m_rdata_known = 1'b1;
          m_resp_wr     = 1'b0;
          chk_en        = 1'b1;
        end else if (age < 0) begin
          if (req_valid) begin
            age     = 0;
            m_wr    = req_wr;
            m_idx   = req_addr[9:2];
            m_wdata = req_wdata;
          end
        end else begin
          age++;
          if (age == LAT) begin
            if (m_wr) begin
              m_mem[m_idx]   = m_wdata;
              m_known[m_idx] = 1'b1;
              m_rdata        = m_wdata;
              m_rdata_known  = 1'b1;
            end else begin
              m_rdata       = m_mem[m_idx];
              m_rdata_known = m_known[m_idx];
            end
            m_resp_wr = m_wr;
          end else if (age == LAT + 1) begin
            age = -1;
          end
        end
      end
    end

    // Present a request and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      bit got = 1'b0;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = data;
      req_valid = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        if (req_ready) begin
          got = 1'b1;
          @(posedge clk);
          #1;
        end
      end
      req_valid = 1'b0;
      if (!got) chk("accept timeout", 32'(got), 32'd1);
    endtask

    // Count edges from the accept edge until resp_valid is seen.
    task automatic wait_resp(output int lat, output logic [31:0] d, output logic w);
      bit got = 1'b0;
      lat = 0;
      d   = 32'd0;
      w   = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
        @(posedge clk);
        #1;
        if (resp_valid) begin
          got = 1'b1;
          lat = c;
          d   = resp_rdata;
          w   = resp_wr;
        end
      end
      if (!got) chk("response timeout", 32'(got), 32'd1);
    endtask

    task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    endtask

    initial begin
      int          lat;
      logic [31:0] d;
      logic        w;
      time         t0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset ready", 32'(req_ready), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_wr", 32'(resp_wr), 32'd0);
      chk("reset rdata", resp_rdata, 32'd0);

      for (int k = 0; k < 16; k++) begin
        do_req(1'b1, 32'(k) << 2, 32'h1000_0000 + 32'(k));
        wait_resp(lat, d, w);
      end

      do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      wait_resp(lat, d, w);
      chk("write latency", 32'(lat), (gi == 0) ? 32'd4 : 32'd1);
      chk("write ack data", d, 32'hDEAD_BEEF);
      chk("write ack wr", 32'(w), 32'd1);
      @(posedge clk);
      #1;
      chk("pulse one cycle", 32'(resp_valid), 32'd0);
      chk("ready after resp", 32'(req_ready), 32'd1);

      do_req(1'b1, 32'h0000_0014, 32'h0000_0001);
      wait_resp(lat, d, w);
      do_req(1'b0, 32'h0000_0010, 32'h0);
      wait_resp(lat, d, w);
      chk("read latency", 32'(lat), (gi == 0) ? 32'd4 : 32'd1);
      chk("read 0x10", d, 32'hDEAD_BEEF);
      chk("read wr flag", 32'(w), 32'd0);
      do_req(1'b0, 32'h0000_0014, 32'h0);
      wait_resp(lat, d, w);
      chk("read 0x14", d, 32'h0000_0001);

      do_req(1'b1, 32'h0000_0400, 32'hA5A5_A5A5);
      wait_resp(lat, d, w);
      do_req(1'b0, 32'h0000_0000, 32'h0);
      wait_resp(lat, d, w);
      chk("alias read", d, 32'hA5A5_A5A5);

      do_req(1'b1, 32'h0000_0020, 32'h1111_1111);
      wait_resp(lat, d, w);
      do_req(1'b1, 32'h0000_0020, 32'h2222_2222);
      pulse_rst();
      chk("abort resp_valid", 32'(resp_valid), 32'd0);
      chk("abort ready", 32'(req_ready), 32'd1);
      repeat (LAT + 2) @(posedge clk);
      #1;
      do_req(1'b0, 32'h0000_0023, 32'h0);
      wait_resp(lat, d, w);
      chk("aborted write dropped", d, 32'h1111_1111);

      // Back-to-back reads: acceptance spacing is LATENCY+2 cycles.
      do_req(1'b0, 32'h0000_0010, 32'h0);
      t0 = $time;
      do_req(1'b0, 32'h0000_0014, 32'h0);
      chk("throughput", 32'(($time - t0) / 10), (gi == 0) ? 32'd6 : 32'd3);
      wait_resp(lat, d, w);
      chk("b2b read", d, 32'h0000_0001);

      for (int it = 0; it < 120; it++) begin
        int          gap;
        logic [31:0] addr;
        addr = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
        do_req(1'($urandom_range(0, 1)), addr, $urandom);
        if ($urandom_range(0, 19) == 0) pulse_rst();
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      repeat (LAT + 4) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 60000 && !(g[0].done && g[1].done); c++) @(posedge clk);
    if (!(g[0].done && g[1].done)) check("bench timeout", 32'(g[0].done && g[1].done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
